packet_sender: RTL
==================

// Module: packet_sender
// PURPOSE
//  Downstream of the 32-to-8 storage converter: drains stored sample bytes and frames them into
//  fixed-length packets for the host byte link (UART/USB TX). Drives the storage ReadEnable
//  and presents a valid/ready byte stream to the transmitter. All logic on ReadClock.
// PARAMETERS
//  PAYLOAD_LEN   256  payload bytes per packet (1..65535); sent as 16-bit length field
//  SYNC0         8'hA5 first sync byte
//  SYNC1         8'h5A second sync byte
//  VALID_TIMEOUT 4    cycles to wait for StoreValid after a read before declaring underrun
// PORTS
//  ReadClock        in   1  clock
//  Reset            in   1  synchronous, active-high
//  Enable           in   1  permits starting a new packet
//  StoreReady       in   1  storage holds >=1 byte (storage DataReadyToSend)
//  StoreData        in   8  storage byte (storage DataOut)
//  StoreValid       in   1  StoreData valid this cycle (storage DataValid)
//  StoreReadEnable  out  1  one-cycle read strobe to storage (storage ReadEnable)
//  TxData           out  8  byte to transmitter
//  TxValid          out  1  TxData valid
//  TxReady          in   1  transmitter accepts byte when TxValid&&TxReady
//  Busy             out  1  high from packet start until PacketDone
//  PacketDone       out  1  one-cycle pulse after checksum byte accepted
//  Underrun         out  1  sticky: a pad byte was sent; cleared by Reset or next packet start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; SEQ counter 0; checksum 0; byte counter 0.
//  Frame: SYNC0, SYNC1, SEQ, LEN[15:8], LEN[7:0], PAYLOAD_LEN payload bytes, CSUM.
//   CSUM = 8-bit mod-256 sum of SEQ, LEN hi, LEN lo and all payload bytes (sync excluded).
//   SEQ increments (wraps 255->0) on each PacketDone.
//  TX handshake: byte transfers on TxValid&&TxReady; while TxValid&&!TxReady, TxData and
//   TxValid held stable. TxValid may stay high back-to-back; no combinational TxReady->TxValid.
//  States:
//   IDLE   : Busy=0. If Enable&&StoreReady -> HDR (Busy=1, Underrun cleared, csum=0, cnt=0).
//   HDR    : sends SYNC0,SYNC1,SEQ,LEN hi,LEN lo in order, one per transfer -> FETCH.
//   FETCH  : if StoreReady: StoreReadEnable=1 for exactly one cycle -> WAIT.
//            if !StoreReady: stall (no timeout here; TxValid=0).
//   WAIT   : latch StoreData on first StoreValid -> SEND. If no StoreValid within
//            VALID_TIMEOUT cycles: byte=8'h00, Underrun=1 -> SEND.
//   SEND   : present latched byte; on transfer csum+=byte, cnt+=1;
//            cnt==PAYLOAD_LEN -> CSUM else -> FETCH.
//   CSUM   : present checksum; on transfer PacketDone=1 for one cycle, SEQ+=1 -> IDLE.
//  Only one storage read outstanding; StoreValid outside WAIT is ignored.
//  Enable deasserted mid-packet: packet completes; only gates start in IDLE.
//  Reset mid-packet: immediate return to IDLE, TxValid dropped, partial frame abandoned, SEQ=0.
//  Read latency from storage: StoreValid normally 1 cycle after StoreReadEnable.
// TESTING
//  1 PAYLOAD_LEN=4, storage holds 01 02 03 04, TxReady=1 -> TX stream A5 5A 00 00 04 01 02 03 04 0E,
//    PacketDone pulse once, 4 StoreReadEnable strobes, Underrun=0.
//  2 Repeat with bytes 01..04 again -> SEQ=01, CSUM=0F; Busy low between packets.
//  3 TxReady toggled 1-of-3 cycles -> identical byte sequence, TxData stable while stalled.
//  4 StoreValid suppressed for 3rd payload byte -> pad 00 sent, Underrun=1, CSUM=0B.
//  5 Reset asserted after 2nd payload byte -> next cycle TxValid=0, Busy=0; next packet SEQ=00.
//  6 Enable=0 with StoreReady=1 -> no StoreReadEnable, TxValid stays 0 for 100 cycles.

Source files
------------

// File: rtl/packet_sender.sv
// Frames bytes drained from the sample store into fixed-length packets:
// SYNC0 SYNC1 SEQ LENhi LENlo payload... CSUM, streamed over a valid/ready byte link.
module packet_sender #(
  parameter int          PAYLOAD_LEN   = 256,
  parameter logic [7:0]  SYNC0         = 8'hA5,
  parameter logic [7:0]  SYNC1         = 8'h5A,
  parameter int          VALID_TIMEOUT = 4
) (
  input  logic       ReadClock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       StoreReady,
  input  logic [7:0] StoreData,
  input  logic       StoreValid,
  output logic       StoreReadEnable,
  output logic [7:0] TxData,
  output logic       TxValid,
  input  logic       TxReady,
  output logic       Busy,
  output logic       PacketDone,
  output logic       Underrun,
  output logic [2:0] DebugState
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    FETCH = 3'd2,
    WAIT  = 3'd3,
    SEND  = 3'd4,
    CSUM  = 3'd5
  } state_t;

  localparam logic [15:0] LEN = 16'(PAYLOAD_LEN);
  localparam int          WW  = $clog2(VALID_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(VALID_TIMEOUT - 1);

  state_t        state, nextState;
  logic [2:0]    hdrIdx;
  logic [7:0]    seq;
  logic [7:0]    csum;
  logic [15:0]   cnt;
  logic [WW-1:0] waitCnt;
  logic [7:0]    byteReg;
  logic          underrunReg;
  logic          packetDoneReg;

  // TX link: a byte moves on TxValid && TxReady. TxValid and TxData depend only
  // on registered state, so they hold steady while the transmitter stalls.
  logic txFire;
  assign txFire = TxValid && TxReady;

  logic startPacket;
  assign startPacket = (state == IDLE) && Enable && StoreReady;

  logic waitTimeout;
  assign waitTimeout = !StoreValid && (waitCnt == WAIT_LAST);

  always_ff @(posedge ReadClock) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (startPacket) nextState = HDR;
      HDR:   if (txFire && hdrIdx == 3'd4) nextState = FETCH;
      FETCH: if (StoreReady) nextState = WAIT;
      WAIT:  if (StoreValid || waitTimeout) nextState = SEND;
      SEND:  if (txFire) nextState = ((cnt + 16'd1) == LEN) ? CSUM : FETCH;
      CSUM:  if (txFire) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge ReadClock) begin
    if (Reset) begin
      hdrIdx        <= '0;
      seq           <= '0;
      csum          <= '0;
      cnt           <= '0;
      waitCnt       <= '0;
      byteReg       <= '0;
      underrunReg   <= 1'b0;
      packetDoneReg <= 1'b0;
    end else begin
      packetDoneReg <= 1'b0;
      case (state)
        IDLE: if (startPacket) begin
          underrunReg <= 1'b0;
          csum        <= '0;
          cnt         <= '0;
          hdrIdx      <= '0;
        end
        HDR: if (txFire) begin
          hdrIdx <= hdrIdx + 3'd1;
          // Sync bytes are excluded from the checksum.
          if (hdrIdx >= 3'd2) csum <= csum + TxData;
        end
        FETCH: waitCnt <= '0;
        WAIT: begin
          if (StoreValid) begin
            byteReg <= StoreData;
          end else if (waitTimeout) begin
            byteReg     <= 8'h00;
            underrunReg <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        SEND: if (txFire) begin
          csum <= csum + byteReg;
          cnt  <= cnt + 16'd1;
        end
        CSUM: if (txFire) begin
          packetDoneReg <= 1'b1;
          seq           <= seq + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    TxValid         = 1'b0;
    TxData          = 8'h00;
    StoreReadEnable = 1'b0;
    Busy            = (state != IDLE);
    case (state)
      HDR: begin
        TxValid = 1'b1;
        case (hdrIdx)
          3'd0:    TxData = SYNC0;
          3'd1:    TxData = SYNC1;
          3'd2:    TxData = seq;
          3'd3:    TxData = LEN[15:8];
          default: TxData = LEN[7:0];
        endcase
      end
      FETCH: StoreReadEnable = StoreReady;
      SEND: begin
        TxValid = 1'b1;
        TxData  = byteReg;
      end
      CSUM: begin
        TxValid = 1'b1;
        TxData  = csum;
      end
      default: ;
    endcase
  end

  assign PacketDone = packetDoneReg;
  assign Underrun   = underrunReg;
  assign DebugState = state;

endmodule
